// File: rtl/core2axi_mo.sv
// Bridges a single-beat core data port onto AXI4 with up to MAX_OUTSTANDING
// transactions in flight, all in one direction at a time.
module core2axi_mo #(
    parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI4_DATA_WIDTH    = 32,
    parameter int unsigned AXI4_ID_WIDTH      = 4,
    parameter int unsigned AXI4_USER_WIDTH    = 1,
    parameter int unsigned MAX_OUTSTANDING    = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            data_req_i,
    output logic                            data_gnt_o,
    output logic                            data_rvalid_o,
    output logic                            data_err_o,
    input  logic [AXI4_ADDRESS_WIDTH-1:0]   data_addr_i,
    input  logic                            data_we_i,
    input  logic [3:0]                      data_be_i,
    input  logic [31:0]                     data_wdata_i,
    output logic [31:0]                     data_rdata_o,
    output logic [AXI4_ID_WIDTH-1:0]        aw_id_o,
    output logic [AXI4_ADDRESS_WIDTH-1:0]   aw_addr_o,
    output logic [7:0]                      aw_len_o,
    output logic [2:0]                      aw_size_o,
    output logic [1:0]                      aw_burst_o,
    output logic                            aw_lock_o,
    output logic [3:0]                      aw_cache_o,
    output logic [2:0]                      aw_prot_o,
    output logic [3:0]                      aw_region_o,
    output logic [3:0]                      aw_qos_o,
    output logic [AXI4_USER_WIDTH-1:0]      aw_user_o,
    output logic                            aw_valid_o,
    input  logic                            aw_ready_i,
    output logic [AXI4_DATA_WIDTH-1:0]      w_data_o,
    output logic [AXI4_DATA_WIDTH/8-1:0]    w_strb_o,
    output logic                            w_last_o,
    output logic [AXI4_USER_WIDTH-1:0]      w_user_o,
    output logic                            w_valid_o,
    input  logic                            w_ready_i,
    input  logic [AXI4_ID_WIDTH-1:0]        b_id_i,
    input  logic [1:0]                      b_resp_i,
    input  logic [AXI4_USER_WIDTH-1:0]      b_user_i,
    input  logic                            b_valid_i,
    output logic                            b_ready_o,
    output logic [AXI4_ID_WIDTH-1:0]        ar_id_o,
    output logic [AXI4_ADDRESS_WIDTH-1:0]   ar_addr_o,
    output logic [7:0]                      ar_len_o,
    output logic [2:0]                      ar_size_o,
    output logic [1:0]                      ar_burst_o,
    output logic                            ar_lock_o,
    output logic [3:0]                      ar_cache_o,
    output logic [2:0]                      ar_prot_o,
    output logic [3:0]                      ar_region_o,
    output logic [3:0]                      ar_qos_o,
    output logic [AXI4_USER_WIDTH-1:0]      ar_user_o,
    output logic                            ar_valid_o,
    input  logic                            ar_ready_i,
    input  logic [AXI4_ID_WIDTH-1:0]        r_id_i,
    input  logic [AXI4_DATA_WIDTH-1:0]      r_data_i,
    input  logic [1:0]                      r_resp_i,
    input  logic                            r_last_i,
    input  logic [AXI4_USER_WIDTH-1:0]      r_user_i,
    input  logic                            r_valid_i,
    output logic                            r_ready_o
);

    localparam int unsigned NUM_LANES = AXI4_DATA_WIDTH / 32;
    localparam int unsigned LANE_W    = $clog2(NUM_LANES);
    localparam int unsigned LANE_WP   = (LANE_W == 0) ? 1 : LANE_W;
    localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    if (!(AXI4_DATA_WIDTH == 32 || AXI4_DATA_WIDTH == 64 || AXI4_DATA_WIDTH == 128)) begin : gen_bad_dw
        $error("core2axi_mo: AXI4_DATA_WIDTH must be 32, 64 or 128");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : gen_bad_mo
        $error("core2axi_mo: MAX_OUTSTANDING must be a power of two in 1..16");
    end

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic               can_issue, aw_hs, w_hs, rd_gnt, wr_gnt, r_hs, b_hs;
    logic [LANE_WP-1:0] req_lane, head_lane;

    // Constant AXI attributes: single INCR beat of 4 bytes, ID 0.
    assign aw_id_o     = '0;
    assign aw_len_o    = 8'd0;
    assign aw_size_o   = 3'b010;
    assign aw_burst_o  = 2'b01;
    assign aw_lock_o   = 1'b0;
    assign aw_cache_o  = 4'd0;
    assign aw_prot_o   = 3'd0;
    assign aw_region_o = 4'd0;
    assign aw_qos_o    = 4'd0;
    assign aw_user_o   = '0;
    assign ar_id_o     = '0;
    assign ar_len_o    = 8'd0;
    assign ar_size_o   = 3'b010;
    assign ar_burst_o  = 2'b01;
    assign ar_lock_o   = 1'b0;
    assign ar_cache_o  = 4'd0;
    assign ar_prot_o   = 3'd0;
    assign ar_region_o = 4'd0;
    assign ar_qos_o    = 4'd0;
    assign ar_user_o   = '0;
    assign w_last_o    = 1'b1;
    assign w_user_o    = '0;
    assign aw_addr_o   = data_addr_i;
    assign ar_addr_o   = data_addr_i;
    assign w_data_o    = {NUM_LANES{data_wdata_i}};

    logic unused_inputs;
    assign unused_inputs = ^{b_id_i, b_user_i, r_id_i, r_user_i, r_last_i, b_resp_i[0], r_resp_i[0]};

    // Issue, grant and response decode; reset forces every handshake low.
    always_comb begin
        can_issue  = rst_ni && data_req_i && (cnt_q != CNT_W'(MAX_OUTSTANDING)) &&
                     ((cnt_q == '0) || (dir_q == data_we_i));
        ar_valid_o = can_issue && !data_we_i;
        aw_valid_o = can_issue && data_we_i && !aw_done_q;
        w_valid_o  = can_issue && data_we_i && !w_done_q;
        aw_hs      = aw_valid_o && aw_ready_i;
        w_hs       = w_valid_o && w_ready_i;
        rd_gnt     = ar_valid_o && ar_ready_i;
        wr_gnt     = can_issue && data_we_i && (aw_done_q || aw_hs) && (w_done_q || w_hs);
        data_gnt_o = rd_gnt || wr_gnt;
        r_ready_o  = rst_ni && (cnt_q != '0) && !dir_q;
        b_ready_o  = rst_ni && (cnt_q != '0) && dir_q;
        r_hs       = r_valid_i && r_ready_o;
        b_hs       = b_valid_i && b_ready_o;
        data_rvalid_o = r_hs || b_hs;
        data_err_o    = (r_hs && r_resp_i[1]) || (b_hs && b_resp_i[1]);
    end

    // Lane steering for write strobes and read data.
    always_comb begin
        w_strb_o     = '0;
        data_rdata_o = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (req_lane == LANE_WP'(l)) w_strb_o[l*4 +: 4] = data_be_i;
            if (r_hs && head_lane == LANE_WP'(l)) data_rdata_o = r_data_i[l*32 +: 32];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({data_gnt_o, data_rvalid_o})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        dir_d     = data_gnt_o ? data_we_i : dir_q;
        aw_done_d = wr_gnt ? 1'b0 : (aw_done_q || aw_hs);
        w_done_d  = wr_gnt ? 1'b0 : (w_done_q || w_hs);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Read lane FIFO remembers which 32-bit lane each outstanding read returns on.
    if (LANE_W > 0) begin : gen_fifo
        logic [LANE_W-1:0] mem_q [MAX_OUTSTANDING];
        logic [LANE_W-1:0] mem_d [MAX_OUTSTANDING];
        logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;

        assign req_lane  = data_addr_i[LANE_W+1:2];
        assign head_lane = mem_q[rptr_q];

        always_comb begin
            mem_d  = mem_q;
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            if (rd_gnt) begin
                mem_d[wptr_q] = req_lane;
                wptr_d = (wptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PTR_W'(1);
            end
            if (r_hs) begin
                rptr_d = (rptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PTR_W'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
            end
            mem_q <= mem_d;
        end
    end else begin : gen_no_fifo
        assign req_lane  = '0;
        assign head_lane = '0;
    end

endmodule

// File: tb/tb_core2axi_mo.sv
// Bench for core2axi_mo: lane vectors on a 128-bit instance, directed corner
// sequences and random traffic against a queue-based model on a 64-bit instance.
module tb_core2axi_mo;
    localparam int unsigned AW = 32, DW = 64, IDW = 4, UW = 1, MO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, req, we, gnt, rvalid, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready, w_last;
    logic b_valid, b_ready, r_valid, r_ready, r_last;
    logic [1:0] b_resp, r_resp;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [DW-1:0] w_data, r_data;
    logic [DW/8-1:0] w_strb;
    logic [IDW-1:0] aw_id, ar_id;
    logic [7:0] aw_len, ar_len;
    logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0] aw_burst, ar_burst;
    logic aw_lock, ar_lock;
    logic [3:0] aw_cache, ar_cache, aw_region, ar_region, aw_qos, ar_qos;
    logic [UW-1:0] aw_user, ar_user, w_user;

    core2axi_mo #(.AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IDW),
                  .AXI4_USER_WIDTH(UW), .MAX_OUTSTANDING(MO)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_o(gnt),
        .data_rvalid_o(rvalid), .data_err_o(err), .data_addr_i(addr), .data_we_i(we),
        .data_be_i(be), .data_wdata_i(wdata), .data_rdata_o(rdata),
        .aw_id_o(aw_id), .aw_addr_o(aw_addr), .aw_len_o(aw_len), .aw_size_o(aw_size),
        .aw_burst_o(aw_burst), .aw_lock_o(aw_lock), .aw_cache_o(aw_cache), .aw_prot_o(aw_prot),
        .aw_region_o(aw_region), .aw_qos_o(aw_qos), .aw_user_o(aw_user),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
        .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last), .w_user_o(w_user),
        .w_valid_o(w_valid), .w_ready_i(w_ready),
        .b_id_i(4'hF), .b_resp_i(b_resp), .b_user_i(1'b1), .b_valid_i(b_valid), .b_ready_o(b_ready),
        .ar_id_o(ar_id), .ar_addr_o(ar_addr), .ar_len_o(ar_len), .ar_size_o(ar_size),
        .ar_burst_o(ar_burst), .ar_lock_o(ar_lock), .ar_cache_o(ar_cache), .ar_prot_o(ar_prot),
        .ar_region_o(ar_region), .ar_qos_o(ar_qos), .ar_user_o(ar_user),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .r_id_i(4'hA), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last),
        .r_user_i(1'b1), .r_valid_i(r_valid), .r_ready_o(r_ready)
    );

    // 128-bit instance used only for combinational lane/strobe vectors.
    logic [31:0] t_addr, t_wdata, q_rdata, q_aw_addr, q_ar_addr;
    logic [3:0] t_be;
    logic [127:0] q_w_data;
    logic [15:0] q_w_strb;
    logic q_gnt, q_rv, q_err, q_awv, q_wv, q_arv, q_bready, q_rready, q_wlast, q_awlock, q_arlock;
    logic [IDW-1:0] q_awid, q_arid;
    logic [7:0] q_awlen, q_arlen;
    logic [2:0] q_awsize, q_arsize, q_awprot, q_arprot;
    logic [1:0] q_awburst, q_arburst;
    logic [3:0] q_awcache, q_arcache, q_awregion, q_arregion, q_awqos, q_arqos;
    logic [UW-1:0] q_awuser, q_aruser, q_wuser;

    core2axi_mo #(.AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(128), .AXI4_ID_WIDTH(IDW),
                  .AXI4_USER_WIDTH(UW), .MAX_OUTSTANDING(MO)) u_dut128 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(1'b0), .data_gnt_o(q_gnt),
        .data_rvalid_o(q_rv), .data_err_o(q_err), .data_addr_i(t_addr), .data_we_i(1'b1),
        .data_be_i(t_be), .data_wdata_i(t_wdata), .data_rdata_o(q_rdata),
        .aw_id_o(q_awid), .aw_addr_o(q_aw_addr), .aw_len_o(q_awlen), .aw_size_o(q_awsize),
        .aw_burst_o(q_awburst), .aw_lock_o(q_awlock), .aw_cache_o(q_awcache), .aw_prot_o(q_awprot),
        .aw_region_o(q_awregion), .aw_qos_o(q_awqos), .aw_user_o(q_awuser),
        .aw_valid_o(q_awv), .aw_ready_i(1'b0),
        .w_data_o(q_w_data), .w_strb_o(q_w_strb), .w_last_o(q_wlast), .w_user_o(q_wuser),
        .w_valid_o(q_wv), .w_ready_i(1'b0),
        .b_id_i(4'h0), .b_resp_i(2'b00), .b_user_i(1'b0), .b_valid_i(1'b0), .b_ready_o(q_bready),
        .ar_id_o(q_arid), .ar_addr_o(q_ar_addr), .ar_len_o(q_arlen), .ar_size_o(q_arsize),
        .ar_burst_o(q_arburst), .ar_lock_o(q_arlock), .ar_cache_o(q_arcache), .ar_prot_o(q_arprot),
        .ar_region_o(q_arregion), .ar_qos_o(q_arqos), .ar_user_o(q_aruser),
        .ar_valid_o(q_arv), .ar_ready_i(1'b0),
        .r_id_i(4'h0), .r_data_i(128'h0), .r_resp_i(2'b00), .r_last_i(1'b0),
        .r_user_i(1'b0), .r_valid_i(1'b0), .r_ready_o(q_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: queue of outstanding transactions, each remembering direction and lane.
    typedef struct { bit we; int lane; } ent_t;
    ent_t mq[$];
    bit m_dir, m_awd, m_wd;

    logic s_gnt, s_ar, s_aw, s_w, s_rv, s_err, s_rr, s_br;
    logic [31:0] s_rdata;

    task automatic tick();
        bit ok, e_ar, e_aw, e_w, e_gnt, e_rr, e_br, e_rv, e_err, rhs, bhs;
        int n, lane;
        logic [63:0] sh;
        logic [31:0] e_rdata;
        #1;
        s_gnt = gnt; s_ar = ar_valid; s_aw = aw_valid; s_w = w_valid;
        s_rv = rvalid; s_err = err; s_rr = r_ready; s_br = b_ready; s_rdata = rdata;
        n = mq.size();
        lane = int'((addr % 8) / 4);
        if (!rst_n) begin
            {ok, e_ar, e_aw, e_w, e_gnt, e_rr, e_br, rhs, bhs} = '0;
        end else begin
            ok    = req && n < MO && (n == 0 || m_dir == we);
            e_ar  = ok && !we;
            e_aw  = ok && we && !m_awd;
            e_w   = ok && we && !m_wd;
            e_gnt = (e_ar && ar_ready) || (ok && we && (m_awd || aw_ready) && (m_wd || w_ready));
            e_rr  = n > 0 && !m_dir;
            e_br  = n > 0 && m_dir;
            rhs   = r_valid && e_rr;
            bhs   = b_valid && e_br;
        end
        e_rv  = rhs || bhs;
        e_err = rhs ? r_resp[1] : (bhs ? b_resp[1] : 1'b0);
        e_rdata = 32'h0;
        if (rhs) begin
            sh = r_data >> (32 * mq[0].lane);
            e_rdata = sh[31:0];
        end
        chk("gnt", gnt, e_gnt);
        chk("ar_valid", ar_valid, e_ar);
        chk("aw_valid", aw_valid, e_aw);
        chk("w_valid", w_valid, e_w);
        chk("r_ready", r_ready, e_rr);
        chk("b_ready", b_ready, e_br);
        chk("rvalid", rvalid, e_rv);
        chk("err", err, e_err);
        if (e_rv) chk("rdata", rdata, e_rdata);
        if (req) begin
            chk("w_strb", w_strb, 8'(be) << (4 * lane));
            chk("w_data", w_data, {wdata, wdata});
            chk("ar_addr", ar_addr, addr);
            chk("aw_addr", aw_addr, addr);
        end
        if (!rst_n) begin
            mq.delete(); m_dir = 0; m_awd = 0; m_wd = 0;
        end else begin
            if (e_rv) void'(mq.pop_front());
            if (e_gnt) begin
                mq.push_back('{we: we, lane: lane});
                m_dir = we; m_awd = 0; m_wd = 0;
            end else begin
                if (e_aw && aw_ready) m_awd = 1;
                if (e_w && w_ready) m_wd = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        req = 0; we = 0; addr = 0; be = 4'hF; wdata = 0;
        aw_ready = 0; w_ready = 0; ar_ready = 0;
        b_valid = 0; b_resp = 0; r_valid = 0; r_resp = 0; r_data = 0; r_last = 0;
    endtask

    typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic [15:0] strb; } vec_t;
    vec_t vt[6];
    logic [63:0] rd_in [5];
    logic [31:0] rd_exp [5];

    initial begin
        int g;
        vt[0] = '{32'h0000_0008, 4'b0011, 32'hDEAD_BEEF, 16'h0300};
        vt[1] = '{32'h0000_0000, 4'b1111, 32'h1234_5678, 16'h000F};
        vt[2] = '{32'h0000_0004, 4'b1000, 32'hA5A5_5A5A, 16'h0080};
        vt[3] = '{32'h0000_000C, 4'b0101, 32'h0F0F_F0F0, 16'h5000};
        vt[4] = '{32'h0000_01F4, 4'b1111, 32'h8000_0001, 16'h00F0};
        vt[5] = '{32'hFFFF_FFF8, 4'b0110, 32'h0000_0000, 16'h0600};
        rd_in[0] = 64'h11111111_22222222; rd_exp[0] = 32'h22222222;
        rd_in[1] = 64'h11111111_22222222; rd_exp[1] = 32'h11111111;
        rd_in[2] = 64'h33333333_44444444; rd_exp[2] = 32'h44444444;
        rd_in[3] = 64'h33333333_44444444; rd_exp[3] = 32'h33333333;
        rd_in[4] = 64'h55555555_66666666; rd_exp[4] = 32'h66666666;

        set_idle();
        rst_n = 0;
        t_addr = 0; t_be = 0; t_wdata = 0;
        @(negedge clk);

        foreach (vt[i]) begin
            t_addr = vt[i].addr; t_be = vt[i].be; t_wdata = vt[i].wd;
            #1;
            chk("dw128_strb", q_w_strb, vt[i].strb);
            chk("dw128_wdata", q_w_data, {4{vt[i].wd}});
            chk("dw128_awaddr", q_aw_addr, vt[i].addr);
        end
        chk("const_size", aw_size, 3'b010);
        chk("const_burst", ar_burst, 2'b01);
        chk("const_len", aw_len, 8'd0);
        chk("const_wlast", w_last, 1'b1);
        chk("const_ids", {aw_id, ar_id, aw_cache, ar_prot, aw_qos, w_user}, 0);
        @(negedge clk);

        // Requests during reset must not issue anything.
        req = 1; ar_ready = 1; r_valid = 1;
        tick(); tick();
        chk("rst_ar", s_ar, 0);
        chk("rst_gnt", s_gnt, 0);
        set_idle();
        rst_n = 1;
        tick();

        // Four back-to-back reads fill the window; the fifth waits.
        ar_ready = 1; g = 0;
        for (int i = 0; i < 4; i++) begin
            req = 1; addr = 32'(i * 4); tick(); g += int'(s_gnt);
        end
        chk("rd4_grants", g, 4);
        addr = 32'h10; tick();
        chk("rd5_stall_gnt", s_gnt, 0);
        chk("rd5_stall_ar", s_ar, 0);
        for (int i = 0; i < 5; i++) begin
            r_valid = 1; r_data = rd_in[i]; tick();
            chk("rd_rvalid", s_rv, 1);
            chk("rd_lane_data", s_rdata, rd_exp[i]);
            if (i == 0) chk("rd_full_resp_no_gnt", s_gnt, 0);
            if (i == 1) chk("rd_gnt_after_resp", s_gnt, 1);
            if (s_gnt) req = 0;
        end
        set_idle(); tick();

        // Write with AW delayed three cycles, error response.
        req = 1; we = 1; addr = 32'h10; be = 4'hF; wdata = 32'hCAFE_F00D; w_ready = 1;
        tick();
        chk("wr_c0_wvalid", s_w, 1);
        chk("wr_c0_gnt", s_gnt, 0);
        for (int c = 1; c < 3; c++) begin
            tick();
            chk("wr_aw_hold", s_aw, 1);
            chk("wr_w_drop", s_w, 0);
            chk("wr_no_gnt", s_gnt, 0);
        end
        aw_ready = 1; tick();
        chk("wr_c3_gnt", s_gnt, 1);
        set_idle(); b_valid = 1; b_resp = 2'b10; tick();
        chk("wr_b_rvalid", s_rv, 1);
        chk("wr_b_err", s_err, 1);
        chk("wr_b_rdata", s_rdata, 0);
        set_idle();

        // Direction change waits for the read to drain.
        ar_ready = 1; req = 1; we = 0; addr = 32'h20; tick();
        chk("dc_rd_gnt", s_gnt, 1);
        ar_ready = 0; we = 1; addr = 32'h24; aw_ready = 1; w_ready = 1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("dc_no_aw", s_aw, 0);
            chk("dc_no_w", s_w, 0);
        end
        r_valid = 1; r_data = 64'hABCD; r_resp = 2'b00; tick();
        chk("dc_rd_resp", s_rv, 1);
        chk("dc_aw_still_low", s_aw, 0);
        r_valid = 0; tick();
        chk("dc_wr_gnt", s_gnt, 1);
        set_idle(); b_valid = 1; b_resp = 2'b01; tick();
        chk("dc_b_err_low", s_err, 0);
        set_idle();

        // Reset with two reads outstanding discards them.
        ar_ready = 1; req = 1; addr = 32'h0; tick(); addr = 32'h4; tick();
        set_idle(); rst_n = 0; tick();
        rst_n = 1; r_valid = 1; r_data = 64'h1; tick();
        chk("rst_rready", s_rr, 0);
        chk("rst_no_rvalid", s_rv, 0);
        set_idle(); req = 1; we = 1; addr = 32'h8; aw_ready = 1; w_ready = 1; tick();
        chk("rst_cnt0_wr_gnt", s_gnt, 1);
        set_idle(); b_valid = 1; tick();
        set_idle(); tick();

        // Random traffic against the model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!req && $urandom_range(0, 2) == 0) begin
                req = 1; we = 1'($urandom_range(0, 1));
                addr = $urandom & 32'hFFFF_FFFC; be = 4'($urandom); wdata = $urandom;
            end
            aw_ready = 1'($urandom_range(0, 1));
            w_ready  = 1'($urandom_range(0, 1));
            ar_ready = 1'($urandom_range(0, 1));
            r_valid  = ($urandom_range(0, 2) == 0);
            b_valid  = ($urandom_range(0, 2) == 0);
            r_data   = {$urandom, $urandom};
            r_resp   = 2'($urandom);
            b_resp   = 2'($urandom);
            r_last   = 1'($urandom);
            tick();
            if (s_gnt) req = 0;
        end
        set_idle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core2axi_mo.md
CORE2AXI_MO -- requirements
Module: core2axi_mo

Interface
REQ-001 SHALL have parameter AXI4_ADDRESS_WIDTH, default 32, address width on core and AXI sides.
REQ-002 SHALL have parameter AXI4_DATA_WIDTH, default 32, AXI data width; legal values 32, 64, 128; any other value SHALL raise an elaboration error in simulation.
REQ-003 SHALL have parameter AXI4_ID_WIDTH, default 4, AXI ID width.
REQ-004 SHALL have parameter AXI4_USER_WIDTH, default 1, AXI user width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, maximum number of accepted transactions without a response; power of two, 1..16.
REQ-006 SHALL have one clock and one reset, clk_i and rst_ni; reset is synchronous and active-low.
REQ-007 SHALL provide the following ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
data_req_i  in  1  core request
data_gnt_o  out  1  request accepted
data_rvalid_o  out  1  response valid
data_err_o  out  1  response error, valid with data_rvalid_o
data_addr_i  in  AXI4_ADDRESS_WIDTH  byte address
data_we_i  in  1  1 = write
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_rdata_o  out  32  read data
aw_valid_o/aw_ready_i, w_valid_o/w_ready_i, ar_valid_o/ar_ready_i  out/in  1  AXI address and write-data handshakes
aw_addr_o, ar_addr_o  out  AXI4_ADDRESS_WIDTH  equal to data_addr_i
w_data_o  out  AXI4_DATA_WIDTH, w_strb_o  out  AXI4_DATA_WIDTH/8, w_last_o  out  1
b_valid_i  in  1, b_resp_i  in  2, b_ready_o  out  1
r_valid_i  in  1, r_data_i  in  AXI4_DATA_WIDTH, r_resp_i  in  2, r_last_i  in  1, r_ready_o  out  1
aw/ar id, len, size, burst, lock, cache, prot, region, qos, user (AXI4 widths), w_user_o, plus b_id_i, b_user_i, r_id_i, r_user_i  constant outputs / ignored inputs.
REQ-008 Constant outputs: all IDs 0, len 0, size 3'b010, burst 2'b01 (INCR), w_last_o 1, all others 0.

Function
REQ-009 Core protocol: data_req_i and all request fields are held stable from assertion until the data_gnt_o cycle; one response is returned per grant, in grant order.
REQ-010 Outstanding counter cnt (0..MAX_OUTSTANDING): +1 on grant, -1 on response; grant and response in the same cycle leave cnt unchanged.
REQ-011 Direction register dir_q is loaded with data_we_i on every grant.
REQ-012 can_issue = data_req_i and cnt < MAX_OUTSTANDING and (cnt == 0 or dir_q == data_we_i); a direction change stalls until cnt == 0.
REQ-013 Read: ar_valid_o = can_issue and not data_we_i; data_gnt_o asserts in the ar_valid_o and ar_ready_i cycle (zero-cycle grant).
REQ-014 Write: aw_valid_o = can_issue and data_we_i and not aw_done; w_valid_o = can_issue and data_we_i and not w_done.
REQ-015 aw_done/w_done are set on their own handshake if the other channel has not yet completed.
REQ-016 Write grant fires in the cycle both channels have completed, counting a handshake in that cycle; aw_done and w_done are cleared on grant.
REQ-017 w_data_o SHALL replicate data_wdata_i across every 32-bit lane; w_strb_o SHALL place data_be_i in lane L = data_addr_i[log2(AXI4_DATA_WIDTH/8)-1:2], with all other bits 0.
REQ-018 Lane FIFO, depth MAX_OUTSTANDING: on read grant, push L; on read response, pop.
REQ-019 Read data: data_rdata_o = r_data_i lane at the FIFO head.
REQ-020 For 32-bit data width, the lane FIFO SHALL be absent and L = 0.
REQ-021 r_ready_o = (cnt != 0 and dir_q == 0); b_ready_o = (cnt != 0 and dir_q == 1).
REQ-022 Responses with ready low are not consumed and SHALL have no effect.
REQ-023 Response: data_rvalid_o asserts combinationally in the cycle of r_valid_i and r_ready_o, or of b_valid_i and b_ready_o.
REQ-024 data_err_o = resp[1] of that handshake (SLVERR/DECERR -> 1; OKAY/EXOKAY -> 0).
REQ-025 data_rdata_o = 0 on write responses; r_last_i is ignored.
REQ-026 At cnt == MAX_OUTSTANDING, no valid asserts; a response in that cycle allows a grant in the following cycle, not the same cycle.

Reset
REQ-027 While rst_ni == 0 at a clk_i edge: cnt = 0, aw_done = w_done = 0, dir_q = 0, lane FIFO empty.
REQ-028 During and after reset, all outputs derive from that cleared state: aw/w/ar valid, ready, data_gnt_o, data_rvalid_o and data_err_o are 0.
REQ-029 Reset mid-operation SHALL discard all outstanding transactions; responses arriving after reset see ready low and are not forwarded.

Verification
REQ-030 Four back-to-back reads at addr 0x0,0x4,0x8,0xC, ar_ready_i = 1, r_valid_i held off -> 4 grants in 4 cycles, fifth stalls; with DW=64, responses r_data 0x11111111_22222222 ... -> rdata 0x22222222, 0x11111111, ... (lane-correct).
REQ-031 Write with w_ready_i = 1 and aw_ready_i delayed 3 cycles -> w handshake cycle 0; aw_valid_o stays high, w_valid_o drops; grant in cycle 3; b_resp 2'b10 -> data_rvalid_o = 1 with data_err_o = 1.
REQ-032 Read outstanding then write requested -> no aw_valid_o/w_valid_o until the read response (cnt = 0); write issued the next cycle.
REQ-033 DW=128, write addr 0x8, be 4'b0011 -> w_strb_o = 0x0300, data replicated 4x.
REQ-034 Reset asserted with 2 reads outstanding, then r_valid_i = 1 after release -> r_ready_o = 0, no data_rvalid_o, cnt = 0.
